// File: rtl/hc595_shift_driver.sv
`default_nettype none
// ============================================================================
// Module   : hc595_shift_driver
// Brief    : Serialises one parallel word onto cascaded 74HC595 parts
//            (ds/shcp), then pulses the storage latch (stcp).
// Revision : 1.0 - initial release
// ============================================================================
module hc595_shift_driver #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              busy,
    output logic              shcp,
    output logic              stcp,
    output logic              ds
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_loaded;
    logic [c_CNT_W-1:0]  r_bit;
    logic [c_CNT_W-1:0]  w_bit_nxt;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_DIV_W-1:0]  w_div_nxt;
    logic                r_shcp;
    logic                w_shcp_nxt;
    logic                r_stcp;
    logic                w_stcp_nxt;
    logic                r_ds;
    logic                w_ds_nxt;
    logic                w_first_bit;
    logic                w_next_bit;
    logic                w_div_wrap;
    logic                w_accept;

    // The register holds the bits still to be sent, with the next one at the
    // end that is shifted out; the first bit goes straight from din to ds.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_first_bit = din[DATA_W-1];
            assign w_loaded    = {din[DATA_W-2:0], 1'b0};
            assign w_next_bit  = r_shift[DATA_W-1];
            assign w_shifted   = {r_shift[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit = din[0];
            assign w_loaded    = {1'b0, din[DATA_W-1:1]};
            assign w_next_bit  = r_shift[0];
            assign w_shifted   = {1'b0, r_shift[DATA_W-1:1]};
        end
    endgenerate

    assign w_accept   = din_valid && (r_state == ST_IDLE);
    assign w_div_wrap = (r_div == c_DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_shcp  <= 1'b0;
            r_stcp  <= 1'b0;
            r_ds    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_div   <= w_div_nxt;
            r_shcp  <= w_shcp_nxt;
            r_stcp  <= w_stcp_nxt;
            r_ds    <= w_ds_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_div_nxt   = r_div;
        w_shcp_nxt  = r_shcp;
        w_stcp_nxt  = r_stcp;
        w_ds_nxt    = r_ds;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_shift_nxt = w_loaded;
                    w_bit_nxt   = '0;
                    w_div_nxt   = '0;
                    w_shcp_nxt  = 1'b0;
                    w_stcp_nxt  = 1'b0;
                    w_ds_nxt    = w_first_bit;
                end
            end

            ST_SHIFT: begin
                if (!w_div_wrap) begin
                    w_div_nxt = r_div + 1'b1;
                end else begin
                    w_div_nxt = '0;
                    if (!r_shcp) begin
                        // Second half of the bit: rising shcp mid-bit.
                        w_shcp_nxt = 1'b1;
                    end else if (r_bit == c_BIT_LAST) begin
                        // ds keeps the last bit while the latch pulses.
                        w_state_nxt = ST_LATCH;
                        w_shcp_nxt  = 1'b0;
                        w_stcp_nxt  = 1'b1;
                    end else begin
                        w_shcp_nxt  = 1'b0;
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = w_shifted;
                        w_ds_nxt    = w_next_bit;
                    end
                end
            end

            ST_LATCH: begin
                if (!w_div_wrap) begin
                    w_div_nxt = r_div + 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_stcp_nxt  = 1'b0;
                    w_ds_nxt    = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign din_ready = (r_state == ST_IDLE);
    assign busy      = ~din_ready;
    assign shcp      = r_shcp;
    assign stcp      = r_stcp;
    assign ds        = r_ds;

endmodule
`default_nettype wire

// File: tb/tb_hc595_shift_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc595_shift_driver
// Brief    : Directed bench for hc595_shift_driver (MSB- and LSB-first
//            instances) with a behavioural 74HC595 model on each output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc595_shift_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_valid;

    logic ready_m, busy_m, shcp_m, stcp_m, ds_m;
    logic ready_l, busy_l, shcp_l, stcp_l, ds_l;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    hc595_shift_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (ready_m),
        .busy      (busy_m),
        .shcp      (shcp_m),
        .stcp      (stcp_m),
        .ds        (ds_m)
    );

    hc595_shift_driver #(.DATA_W(16), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (ready_l),
        .busy      (busy_l),
        .shcp      (shcp_l),
        .stcp      (stcp_l),
        .ds        (ds_l)
    );

    // 74HC595 chain models: shift on shcp rise, copy to outputs on stcp rise.
    logic [15:0] sr_m = '0, latch_m = '0, sr_l = '0, latch_l = '0;
    int shcp_rises_m = 0, stcp_rises_m = 0, overlap = 0;

    always @(posedge shcp_m) begin
        sr_m = {sr_m[14:0], ds_m};
        shcp_rises_m++;
    end
    always @(posedge stcp_m) begin
        latch_m = sr_m;
        stcp_rises_m++;
    end
    always @(posedge shcp_l) sr_l = {sr_l[14:0], ds_l};
    always @(posedge stcp_l) latch_l = sr_l;
    always @(negedge clk) if (stcp_m && shcp_m) overlap++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller drives din=w, din_valid=1 at a negedge while IDLE; the next
    // posedge is the accept edge T0, and sample k is cycle T0+k.
    task automatic run_frame(input logic [15:0] w, input bit hold_valid,
                             input logic [15:0] next_w, input bit disturb,
                             input logic [15:0] exp_lsb);
        int          rises0;
        int          stcp0;
        int          bad_shcp = 0;
        int          bad_stcp = 0;
        int          bad_ready = 0;
        int          bad_busy = 0;
        logic        prev_shcp;
        logic        ds_end = 1'b1;
        logic [15:0] bits_m = '0;
        logic [15:0] bits_l = '0;
        chk("ready_before_accept", ready_m, 1);
        rises0    = shcp_rises_m;
        stcp0     = stcp_rises_m;
        prev_shcp = shcp_m;
        @(posedge clk);
        for (int k = 1; k <= 67; k++) begin
            @(negedge clk);
            if (shcp_m && !prev_shcp) begin
                bits_m = {bits_m[14:0], ds_m};
                bits_l = {bits_l[14:0], ds_l};
            end
            if ((shcp_m && !prev_shcp) != ((k % 4 == 3) && (k <= 63))) bad_shcp++;
            if (stcp_m != ((k == 65) || (k == 66))) bad_stcp++;
            if (ready_m != (k == 67)) bad_ready++;
            if (busy_m == ready_m) bad_busy++;
            if (k == 67) ds_end = ds_m;
            prev_shcp = shcp_m;
            if (k == 1 && !hold_valid) din_valid = 1'b0;
            if (disturb && k >= 5 && k <= 40) begin
                din       = 16'hFFFF;
                din_valid = (k % 2 == 1);
            end
            if (disturb && k == 41) din_valid = 1'b0;
            if (k == 67 && hold_valid) begin
                din       = next_w;
                din_valid = 1'b1;
            end
        end
        chk("shcp_timing", bad_shcp, 0);
        chk("stcp_timing", bad_stcp, 0);
        chk("ready_timing", bad_ready, 0);
        chk("busy_inverse", bad_busy, 0);
        chk("ds_idle_after_latch", ds_end, 0);
        chk("ds_stream_msb", bits_m, w);
        chk("ds_stream_lsb", bits_l, exp_lsb);
        chk("shcp_rise_count", shcp_rises_m - rises0, 16);
        chk("stcp_rise_count", stcp_rises_m - stcp0, 1);
        chk("latch_msb", latch_m, w);
        chk("latch_lsb", latch_l, exp_lsb);
    endtask

    initial begin
        int s0;
        int t0;
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_shcp", shcp_m, 0);
        chk("rst_stcp", stcp_m, 0);
        chk("rst_ds", ds_m, 0);
        chk("rst_ready", ready_m, 1);
        chk("rst_busy", busy_m, 0);
        chk("rst_ready_lsb", ready_l, 1);

        rst_n = 1'b1;
        s0 = shcp_rises_m;
        t0 = stcp_rises_m;
        repeat (100) @(negedge clk);
        chk("idle_shcp_edges", shcp_rises_m - s0, 0);
        chk("idle_stcp_edges", stcp_rises_m - t0, 0);
        chk("idle_ready", ready_m, 1);

        din = 16'hA5C3; din_valid = 1'b1;
        run_frame(16'hA5C3, 1'b0, 16'h0000, 1'b0, 16'hC3A5);

        din = 16'h0001; din_valid = 1'b1;
        run_frame(16'h0001, 1'b0, 16'h0000, 1'b0, 16'h8000);

        din = 16'h1234; din_valid = 1'b1;
        run_frame(16'h1234, 1'b1, 16'h5678, 1'b0, 16'h2C48);
        run_frame(16'h5678, 1'b0, 16'h0000, 1'b0, 16'h1E6A);

        din = 16'h00F0; din_valid = 1'b1;
        run_frame(16'h00F0, 1'b0, 16'h0000, 1'b1, 16'h0F00);

        // Reset in the shcp-high half of bit 7 (a 1 for 16'h81A7).
        din = 16'h81A7; din_valid = 1'b1;
        t0 = stcp_rises_m;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_shcp", shcp_m, 1);
        chk("pre_rst_ds", ds_m, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_shcp", shcp_m, 0);
        chk("midrst_ds", ds_m, 0);
        chk("midrst_stcp", stcp_m, 0);
        chk("midrst_ready", ready_m, 1);
        repeat (3) @(negedge clk);
        chk("midrst_no_stcp", stcp_rises_m - t0, 0);
        chk("midrst_latch_kept", latch_m, 16'h00F0);
        rst_n = 1'b1;
        din = 16'h9A6B; din_valid = 1'b1;
        run_frame(16'h9A6B, 1'b0, 16'h0000, 1'b0, 16'hD659);

        chk("stcp_shcp_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hc595_shift_driver.md
Name: hc595_shift_driver

Overview:
Serialiser stage that drives the cascaded 74HC595 shift registers behind the display top level. It accepts one parallel display word through a valid/ready handshake from the segment/select encoder. It shifts the word out on ds with a divided shift clock shcp, then pulses the storage latch stcp. This block directly produces the shcp/stcp/ds pins.

Parameters:
DATA_W, 16, bits per transaction (e.g. 8 segment bits plus 8 digit-select bits); minimum 2.
CLK_DIV, 2, system clock cycles per shcp half-period and width of the stcp pulse; minimum 1.
MSB_FIRST, 1, 1 sends din[DATA_W-1] first; 0 sends din[0] first.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  reset, asynchronous, active-low.
din  input  DATA_W  parallel word to shift out; sampled only on an accepted handshake.
din_valid  input  1  upstream has a word.
din_ready  output  1  high only in IDLE; transfer occurs when din_valid and din_ready are both high on a clk edge.
busy  output  1  inverse of din_ready.
shcp  output  1  74HC595 shift clock; registered.
stcp  output  1  74HC595 storage/latch clock; registered.
ds  output  1  74HC595 serial data; registered.

Behaviour:
- Single clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, shcp=0, stcp=0, ds=0, din_ready=1, busy=0. Internal shift register, bit counter and divider are all 0.
- States:
  - IDLE: accept the word on handshake, then go to SHIFT.
  - SHIFT: go to LATCH after DATA_W bits.
  - LATCH: go to IDLE after CLK_DIV cycles.
- Timing, with T0 as the accept edge:
  - Bit i (i = 0..DATA_W-1) occupies cycles T0+1+2*CLK_DIV*i through T0+2*CLK_DIV*(i+1).
  - ds carries bit i for all 2*CLK_DIV cycles of that bit.
  - shcp is 0 for the first CLK_DIV cycles of the bit and 1 for the last CLK_DIV cycles.
  - The shcp rising edge therefore sits mid-bit, giving CLK_DIV cycles of setup and hold.
- LATCH: cycles T0+1+2*CLK_DIV*DATA_W through T0+2*CLK_DIV*DATA_W+CLK_DIV.
  - stcp=1, shcp=0, ds holds the last bit.
- Return to IDLE on cycle T0+2*CLK_DIV*DATA_W+CLK_DIV+1.
  - stcp=0, ds=0, din_ready=1 on that same cycle.
  - Back-to-back words are accepted with no extra gap.
- Bit order: MSB_FIRST=1 shifts the captured register left and takes bit [DATA_W-1]. MSB_FIRST=0 shifts right and takes bit [0].
- Exactly DATA_W shcp rising edges and exactly one stcp rising edge per transaction. stcp never rises while shcp=1.
- Divider counts 0..CLK_DIV-1 and wraps. The bit counter is wide enough to hold DATA_W and has no overflow.
- din changes or din_valid drops during SHIFT/LATCH: ignored; the captured word is sent intact.
- din_valid high in IDLE with unchanged din: a new identical transaction still runs (refresh behaviour).
- Reset asserted mid-SHIFT: outputs go to reset values immediately. No stcp pulse occurs, so the 595 outputs keep the previous frame.
- Reset asserted mid-LATCH: stcp drops immediately. The partial pulse is accepted; the frame content is already complete.
- Reset released: din_ready=1 from the first clk edge; a handshake on that first edge is accepted.

Test Plan:
- Reset then idle (DATA_W=16, CLK_DIV=2): rst_n low for 3 cycles -> shcp=stcp=ds=0, din_ready=1. With din_valid=0 for 100 cycles, no shcp/stcp edge.
- Single word: din=16'hA5C3, one-cycle din_valid at T0 -> ds sequence sampled at shcp rising edges is 1010_0101_1100_0011. 16 shcp rises occur at T0+3, T0+7, ..., T0+63. stcp is high on cycles T0+65..T0+66. din_ready returns at T0+67. A 595 model shows 16'hA5C3.
- LSB-first (MSB_FIRST=0): din=16'h0001 -> first sampled bit is 1 and the remaining 15 are 0. The 595 model shows 16'h8000.
- Back-to-back: din_valid held high with 16'h1234 then 16'h5678 -> second accept at T0+67. Two stcp pulses occur with no idle cycle. The model shows 16'h1234 then 16'h5678.
- Mid-transaction disturbance: din switched to 16'hFFFF and din_valid toggled during SHIFT of 16'h00F0 -> output stream is still 16'h00F0 and din_ready stays 0 until T0+67.
- Reset mid-SHIFT: rst_n pulled low at T0+30 -> shcp=ds=0 in the same cycle, no stcp pulse, and the model latch keeps its prior value. A new word after release transfers correctly.
